// File: rtl/usb_rx_sequencer.sv
// USB receive sequencer: checks SYNC/PID of the unstuffed bit stream,
// classifies the packet, gates the external CRC checkers, extracts token
// fields, streams payload bytes with the two CRC bytes held back, and
// issues one result per end-of-packet.
module usb_rx_sequencer #(
  parameter int MAX_DATA_BYTES = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_b,
  input  logic                                  bstr,
  input  logic                                  bstr_avail,
  input  logic                                  bstr_done,
  output logic                                  crc_clr,
  output logic                                  crc5_en,
  output logic                                  crc16_en,
  input  logic                                  crc5_ok,
  input  logic                                  crc16_ok,
  output logic [3:0]                            pid,
  output logic [6:0]                            addr,
  output logic [3:0]                            endp,
  output logic [7:0]                            data_byte,
  output logic                                  data_vld,
  output logic [$clog2(MAX_DATA_BYTES+1)-1:0]   data_cnt,
  output logic                                  pkt_avail,
  output logic                                  pkt_valid,
  output logic [2:0]                            pkt_err
);

  localparam int DATA_BITS_MAX = (MAX_DATA_BYTES + 2) * 8;
  localparam int CNT_W         = $clog2(DATA_BITS_MAX + 2);
  localparam int DCNT_W        = $clog2(MAX_DATA_BYTES + 1);

  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SEVEN    = CNT_W'(7);
  localparam logic [CNT_W-1:0]  ELEVEN   = CNT_W'(11);
  localparam logic [CNT_W-1:0]  SIXTEEN  = CNT_W'(16);
  localparam logic [CNT_W-1:0]  EMIT_MIN = CNT_W'(23);
  localparam logic [CNT_W-1:0]  DATA_LIM = CNT_W'(DATA_BITS_MAX);
  localparam logic [DCNT_W-1:0] DONE_INC = DCNT_W'(1);

  localparam logic [2:0] E_SYNC   = 3'd1;
  localparam logic [2:0] E_PIDCHK = 3'd2;
  localparam logic [2:0] E_PIDUNK = 3'd3;
  localparam logic [2:0] E_LEN    = 3'd4;
  localparam logic [2:0] E_CRC    = 3'd5;
  localparam logic [2:0] E_OVF    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_HSHK, S_DRAIN, S_REPORT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       err, err_n;
  logic [7:0]       shreg;
  logic [7:0]       shift_in;
  logic [7:0]       byte_p0, byte_p1;
  logic             pid_load, tok_bit, byte_done;

  // The error code already recorded wins over any later one.
  function automatic logic [2:0] keep_first(input logic [2:0] cur, input logic [2:0] code);
    return (cur == 3'd0) ? code : cur;
  endfunction

  // Incoming bit merged into the LSB-first shift register.
  assign shift_in = {bstr, shreg[7:1]};

  // State, bit counter and running error code.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state <= S_IDLE;
      cnt   <= '0;
      err   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

  // Next state: consume the bit of this cycle first, then handle end-of-packet.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    err_n     = err;
    crc_clr   = 1'b0;
    crc5_en   = 1'b0;
    crc16_en  = 1'b0;
    pid_load  = 1'b0;
    tok_bit   = 1'b0;
    byte_done = 1'b0;
    pkt_avail = 1'b0;
    pkt_valid = 1'b0;
    if (!rst_b) begin
      case (state)
        S_IDLE: begin
          if (bstr_avail) begin
            cnt_n = ONE;
            if (bstr) begin
              err_n   = E_SYNC;
              state_n = S_DRAIN;
            end else begin
              err_n   = 3'd0;
              state_n = S_SYNC;
            end
          end
        end
        S_SYNC: begin
          if (bstr_avail) begin
            if (bstr != (cnt == SEVEN)) begin
              err_n   = keep_first(err, E_SYNC);
              state_n = S_DRAIN;
            end else if (cnt == SEVEN) begin
              cnt_n   = '0;
              state_n = S_PID;
            end else begin
              cnt_n = cnt + ONE;
            end
          end
        end
        S_PID: begin
          if (bstr_avail) begin
            if (cnt == SEVEN) begin
              crc_clr  = 1'b1;
              pid_load = 1'b1;
              cnt_n    = '0;
              if (shift_in[7:4] != ~shift_in[3:0]) begin
                err_n   = keep_first(err, E_PIDCHK);
                state_n = S_DRAIN;
              end else begin
                case (shift_in[3:0])
                  4'b0001, 4'b1001, 4'b1101: state_n = S_TOKEN;
                  4'b0011, 4'b1011:          state_n = S_DATA;
                  4'b0010, 4'b1010, 4'b1110: state_n = S_HSHK;
                  default: begin
                    err_n   = keep_first(err, E_PIDUNK);
                    state_n = S_DRAIN;
                  end
                endcase
              end
            end else begin
              cnt_n = cnt + ONE;
            end
          end
        end
        S_TOKEN: begin
          if (bstr_avail) begin
            if (cnt == SIXTEEN) begin
              err_n   = keep_first(err, E_LEN);
              state_n = S_DRAIN;
            end else begin
              crc5_en = 1'b1;
              tok_bit = 1'b1;
              cnt_n   = cnt + ONE;
            end
          end
        end
        S_DATA: begin
          if (bstr_avail) begin
            crc16_en = 1'b1;
            if (cnt == DATA_LIM) begin
              err_n   = keep_first(err, E_OVF);
              state_n = S_DRAIN;
            end else begin
              cnt_n     = cnt + ONE;
              byte_done = (cnt[2:0] == 3'd7);
            end
          end
        end
        S_HSHK: begin
          if (bstr_avail) begin
            err_n   = keep_first(err, E_LEN);
            state_n = S_DRAIN;
          end
        end
        S_DRAIN: ;
        S_REPORT: begin
          pkt_avail = 1'b1;
          pkt_valid = (err == 3'd0);
          state_n   = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase

      if (bstr_done && state_n != S_IDLE && state_n != S_REPORT) begin
        case (state_n)
          S_SYNC, S_PID: err_n = keep_first(err_n, E_LEN);
          S_TOKEN: begin
            if (cnt_n != SIXTEEN)  err_n = keep_first(err_n, E_LEN);
            else if (!crc5_ok)     err_n = keep_first(err_n, E_CRC);
          end
          S_DATA: begin
            if (cnt_n < SIXTEEN || cnt_n[2:0] != 3'd0) err_n = keep_first(err_n, E_LEN);
            else if (!crc16_ok)                        err_n = keep_first(err_n, E_CRC);
          end
          default: ;
        endcase
        state_n = S_REPORT;
      end
    end
  end

  // Shift register and two-deep byte delay that holds back the CRC bytes.
  always_ff @(posedge clk) begin
    if (bstr_avail) shreg <= shift_in;
    if (byte_done) begin
      byte_p1 <= byte_p0;
      byte_p0 <= shift_in;
    end
  end

  // Packet fields, payload output and latched result code.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      pid       <= 4'd0;
      addr      <= 7'd0;
      endp      <= 4'd0;
      data_byte <= 8'd0;
      data_vld  <= 1'b0;
      data_cnt  <= '0;
      pkt_err   <= 3'd0;
    end else begin
      data_vld <= 1'b0;
      if (pid_load) begin
        pid      <= shift_in[3:0];
        addr     <= 7'd0;
        endp     <= 4'd0;
        data_cnt <= '0;
      end
      if (tok_bit) begin
        if (cnt < SEVEN)       addr[cnt[2:0]]        <= bstr;
        else if (cnt < ELEVEN) endp[cnt[1:0] + 2'd1] <= bstr;
      end
      if (byte_done && cnt >= EMIT_MIN) begin
        data_byte <= byte_p1;
        data_vld  <= 1'b1;
        data_cnt  <= data_cnt + DONE_INC;
      end
      if (state_n == S_REPORT) pkt_err <= err_n;
    end
  end

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Bench for usb_rx_sequencer: directed packets followed by random ones,
// each compared against a whole-packet reference model.
module tb_usb_rx_sequencer;

  localparam int MAXB  = 8;
  localparam int LIMIT = (MAXB + 2) * 8;

  logic       clk = 1'b0;
  logic       rst_b, bstr, bstr_avail, bstr_done;
  logic       crc_clr, crc5_en, crc16_en, crc5_ok, crc16_ok;
  logic [3:0] pid, endp;
  logic [6:0] addr;
  logic [7:0] data_byte;
  logic       data_vld;
  logic [3:0] data_cnt;
  logic       pkt_avail, pkt_valid;
  logic [2:0] pkt_err;

  usb_rx_sequencer #(.MAX_DATA_BYTES(MAXB)) dut (
    .clk(clk), .rst_b(rst_b), .bstr(bstr), .bstr_avail(bstr_avail),
    .bstr_done(bstr_done), .crc_clr(crc_clr), .crc5_en(crc5_en),
    .crc16_en(crc16_en), .crc5_ok(crc5_ok), .crc16_ok(crc16_ok),
    .pid(pid), .addr(addr), .endp(endp), .data_byte(data_byte),
    .data_vld(data_vld), .data_cnt(data_cnt), .pkt_avail(pkt_avail),
    .pkt_valid(pkt_valid), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          pkt_bits[$];
  byte unsigned got[$];
  byte unsigned exp_bytes[$];
  int n_avail, n_clr, n_c5, n_c16;

  int         e_err, e_c5, e_c16, e_clr;
  bit         e_pid_seen, e_is_tok, e_c16_chk;
  logic [3:0] e_pid, e_endp;
  logic [6:0] e_addr;

  // Observe DUT pulses mid-cycle.
  always @(negedge clk) begin
    if (data_vld)  got.push_back(data_byte);
    if (pkt_avail) n_avail++;
    if (crc_clr)   n_clr++;
    if (crc5_en)   n_c5++;
    if (crc16_en)  n_c16++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) pkt_bits.push_back(b[i]);
  endtask

  task automatic push_pid(input logic [3:0] p);
    push_byte({~p, p});
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) pkt_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  // Whole-packet reference: derives the result from the packet's bit list.
  task automatic model(input bit c5ok, input bit c16ok);
    int n, body, full;
    logic [7:0] p;
    n = pkt_bits.size();
    e_err = 0; e_pid_seen = 0; e_is_tok = 0; e_c16_chk = 0;
    e_addr = '0; e_endp = '0; e_c5 = 0; e_c16 = 0; e_clr = 0;
    exp_bytes.delete();
    for (int i = 0; i < 8 && i < n; i++)
      if (pkt_bits[i] != (i == 7)) begin e_err = 1; return; end
    if (n < 16) begin e_err = 4; return; end
    e_clr = 1;
    e_pid_seen = 1;
    for (int i = 0; i < 8; i++) p[i] = pkt_bits[8 + i];
    e_pid = p[3:0];
    if (p[7:4] != ~p[3:0]) begin e_err = 2; return; end
    body = n - 16;
    case (p[3:0])
      4'd1, 4'd9, 4'd13: begin
        e_is_tok = 1;
        e_c5 = (body < 16) ? body : 16;
        for (int i = 0; i < 11 && i < body; i++)
          if (i < 7) e_addr[i] = pkt_bits[16 + i];
          else       e_endp[i - 7] = pkt_bits[16 + i];
        if (body != 16)  e_err = 4;
        else if (!c5ok)  e_err = 5;
      end
      4'd3, 4'd11: begin
        e_c16_chk = (body <= LIMIT);
        e_c16 = body;
        full = ((body > LIMIT) ? LIMIT : body) / 8;
        for (int k = 0; k < full - 2; k++) begin
          logic [7:0] b;
          for (int i = 0; i < 8; i++) b[i] = pkt_bits[16 + 8 * k + i];
          exp_bytes.push_back(b);
        end
        if (body > LIMIT)                     e_err = 6;
        else if (body < 16 || body % 8 != 0)  e_err = 4;
        else if (!c16ok)                      e_err = 5;
      end
      4'd2, 4'd10, 4'd14: if (body > 0) e_err = 4;
      default: e_err = 3;
    endcase
  endtask

  task automatic clear_counts();
    got.delete();
    n_avail = 0; n_clr = 0; n_c5 = 0; n_c16 = 0;
  endtask

  // Drive pkt_bits with random stalls, then done; check the report.
  task automatic send_pkt(input string tag, input bit c5ok, input bit c16ok, input bit merge);
    int n;
    n = pkt_bits.size();
    model(c5ok, c16ok);
    clear_counts();
    crc5_ok = c5ok;
    crc16_ok = c16ok;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bstr_avail = 1'b0;
        repeat ($urandom_range(1, 2)) step();
      end
      bstr       = pkt_bits[i];
      bstr_avail = 1'b1;
      bstr_done  = merge && (i == n - 1);
      step();
    end
    bstr_avail = 1'b0;
    bstr       = 1'b0;
    if (!merge) begin
      bstr_done = 1'b1;
      step();
    end
    bstr_done = 1'b0;
    check({tag, ".avail"}, pkt_avail, 1);
    check({tag, ".valid"}, pkt_valid, (e_err == 0) ? 1 : 0);
    check({tag, ".err"}, pkt_err, e_err);
    if (e_pid_seen) begin
      check({tag, ".pid"}, pid, e_pid);
      check({tag, ".addr"}, addr, e_addr);
      check({tag, ".endp"}, endp, e_endp);
      check({tag, ".dcnt"}, data_cnt, exp_bytes.size());
    end
    step();
    check({tag, ".avail_end"}, pkt_avail, 0);
    check({tag, ".reports"}, n_avail, 1);
    check({tag, ".crc_clr"}, n_clr, e_clr);
    if (e_is_tok)  check({tag, ".crc5_en"}, n_c5, e_c5);
    if (e_c16_chk) check({tag, ".crc16_en"}, n_c16, e_c16);
    check({tag, ".nbytes"}, got.size(), exp_bytes.size());
    if (got.size() == exp_bytes.size())
      for (int i = 0; i < got.size(); i++) check({tag, ".byte"}, got[i], exp_bytes[i]);
    pkt_bits.delete();
  endtask

  task automatic build_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e, input int nbits);
    logic [15:0] f;
    f = {5'($urandom), e, a};
    push_byte(8'h80);
    push_pid(p);
    for (int i = 0; i < nbits; i++) pkt_bits.push_back(i < 16 ? f[i] : 1'($urandom));
  endtask

  task automatic build_data(input logic [3:0] p, input int nbytes);
    push_byte(8'h80);
    push_pid(p);
    for (int i = 0; i < nbytes; i++) push_byte(8'($urandom));
  endtask

  initial begin
    int kind;
    logic [3:0] rp;
    rst_b = 1'b1; bstr = 1'b0; bstr_avail = 1'b0; bstr_done = 1'b0;
    crc5_ok = 1'b0; crc16_ok = 1'b0;
    clear_counts();
    repeat (3) step();
    check("rst.pid", pid, 0);
    check("rst.addr", addr, 0);
    check("rst.endp", endp, 0);
    check("rst.dcnt", data_cnt, 0);
    check("rst.dvld", data_vld, 0);
    check("rst.avail", pkt_avail, 0);
    check("rst.err", pkt_err, 0);
    check("rst.crc_clr", crc_clr, 0);
    rst_b = 1'b0;
    step();

    // ACK handshake.
    push_byte(8'h80); push_byte(8'hD2);
    send_pkt("ack", 1, 1, 0);

    // OUT token, addr 5, endp 1.
    build_token(4'b0001, 7'h05, 4'h1, 16);
    send_pkt("out", 1, 0, 0);

    // DATA0 with payload 0x11, 0x22 and two CRC bytes.
    push_byte(8'h80); push_pid(4'b0011);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'hA5); push_byte(8'h5A);
    send_pkt("data0", 0, 1, 1);

    // Bad PID check nibble, then trailing bits drained.
    push_byte(8'h80); push_byte(8'hB3); push_rand_bits(24);
    send_pkt("pidchk", 1, 1, 0);

    // 11-byte DATA1 overflows.
    build_data(4'b1011, 11);
    send_pkt("ovf", 1, 1, 0);

    // Reset in the middle of a DATA packet: no report must come out.
    build_data(4'b0011, 6);
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      bstr = pkt_bits[i]; bstr_avail = 1'b1; step();
    end
    bstr_avail = 1'b0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check("rstmid.dcnt", data_cnt, 0);
    check("rstmid.dvld", data_vld, 0);
    repeat (4) step();
    check("rstmid.reports", n_avail, 0);
    pkt_bits.delete();
    push_byte(8'h80); push_byte(8'hD2);
    send_pkt("ack2", 1, 1, 0);

    // SYNC bit error.
    push_byte(8'h84); push_rand_bits(12);
    send_pkt("syncerr", 1, 1, 0);

    // Token ending after 20 field bits.
    build_token(4'b1001, 7'h33, 4'h7, 20);
    send_pkt("tok20", 1, 1, 0);

    // CRC failures, unknown PID, ragged DATA length, long handshake, short PID.
    build_token(4'b1101, 7'h7F, 4'hF, 16);
    send_pkt("tokcrc", 0, 1, 1);
    build_data(4'b0011, 4);
    send_pkt("datcrc", 1, 0, 0);
    push_byte(8'h80); push_pid(4'b0000);
    send_pkt("pidunk", 1, 1, 0);
    build_data(4'b1011, 3); push_rand_bits(3);
    send_pkt("datlen", 1, 1, 0);
    push_byte(8'h80); push_pid(4'b1010); push_rand_bits(2);
    send_pkt("hslong", 1, 1, 0);
    push_byte(8'h80); push_rand_bits(5);
    send_pkt("pidshort", 1, 1, 1);
    build_data(4'b0011, 10);
    send_pkt("datmax", 1, 1, 0);

    // Random packets.
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          case ($urandom_range(0, 2))
            0: rp = 4'b0001;
            1: rp = 4'b1001;
            default: rp = 4'b1101;
          endcase
          build_token(rp, 7'($urandom), 4'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 16);
        end
        1: begin
          build_data($urandom_range(0, 1) ? 4'b0011 : 4'b1011, $urandom_range(0, 12));
          if ($urandom_range(0, 3) == 0) push_rand_bits($urandom_range(1, 7));
        end
        2: begin
          case ($urandom_range(0, 2))
            0: rp = 4'b0010;
            1: rp = 4'b1010;
            default: rp = 4'b1110;
          endcase
          push_byte(8'h80); push_pid(rp);
          if ($urandom_range(0, 3) == 0) push_rand_bits($urandom_range(1, 5));
        end
        3: begin
          push_byte(8'h80); push_byte(8'($urandom)); push_rand_bits($urandom_range(0, 24));
        end
        4: begin
          push_byte(8'h80 ^ (8'd1 << $urandom_range(0, 7))); push_rand_bits($urandom_range(0, 16));
        end
        default: begin
          push_byte(8'h80); push_rand_bits($urandom_range(0, 7));
        end
      endcase
      send_pkt($sformatf("rnd%0d", t), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
